// File: rtl/udc_pkg.sv
// Shared types and constants for the up/down counter: FSM state encoding and
// the up_down direction values.
package udc_pkg;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_RUN_ENC  = 2'd1;
    localparam logic [1:0] ST_HOLD_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_RUN  = ST_RUN_ENC,
        ST_HOLD = ST_HOLD_ENC
    } udc_state_t;

    localparam logic UDC_UP   = 1'b1;
    localparam logic UDC_DOWN = 1'b0;

endpackage

// File: rtl/udc_prescaler.sv
// Tick divider for the up/down counter: one tick every PRESCALE enabled cycles.
// Built into the counter only when UDC_PRESCALE_EN is defined.
module udc_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    // Holds its phase while disabled so a HOLD does not lose partial progress.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/updown_counter_pro.sv
// Up/down counter with run/hold FSM, parallel load, modulus MAX_VAL, wrap or
// saturate mode and a terminal-count pulse. Optional macro: UDC_PRESCALE_EN.
module updown_counter_pro
    import udc_pkg::*;
#(
    parameter int WIDTH    = 7,
    parameter int MAX_VAL  = 127,
    parameter int STEP     = 1,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_down,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             tc
);

    localparam int XW = WIDTH + 1;
    localparam logic [XW-1:0]    STEP_X = XW'(STEP);
    localparam logic [XW-1:0]    MAX_X  = XW'(MAX_VAL);
    localparam logic [XW-1:0]    MOD_X  = XW'(MAX_VAL + 1);
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);

    udc_state_t       state, state_next;
    logic             tick;
    logic             tc_next;
    logic [WIDTH-1:0] count_next;
    logic [XW-1:0]    count_x;
    logic [XW-1:0]    load_x;
    logic [XW-1:0]    sum_x;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // stop dominates start, so a simultaneous request never enters RUN.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_HOLD: if (start && !stop) state_next = ST_RUN;
            ST_RUN:           if (stop) state_next = ST_HOLD;
            default:          state_next = ST_IDLE;
        endcase
    end

`ifdef UDC_PRESCALE_EN
    logic enter_run;
    logic pre_tick;

    assign enter_run = (state != ST_RUN) && (state_next == ST_RUN);

    udc_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (load || enter_run),
        .en   (state == ST_RUN),
        .tick (pre_tick)
    );

    assign tick = (state == ST_RUN) && !load && pre_tick;
`else
    assign tick = (state == ST_RUN) && !load;
`endif

    assign count_x = {1'b0, count};
    assign load_x  = {1'b0, load_val};
    assign sum_x   = count_x + STEP_X;

    // One extra bit of headroom keeps count+STEP and count+MAX_VAL+1 exact.
    always_comb begin
        count_next = count;
        tc_next    = 1'b0;
        if (load) begin
            count_next = (load_x > MAX_X) ? MAX_W : load_val;
        end else if (tick) begin
            if (up_down == UDC_UP) begin
                if (sum_x <= MAX_X) begin
                    count_next = WIDTH'(sum_x);
                end else begin
                    tc_next    = 1'b1;
                    count_next = sat_mode ? MAX_W : WIDTH'(sum_x - MOD_X);
                end
            end else begin
                if (count_x >= STEP_X) begin
                    count_next = WIDTH'(count_x - STEP_X);
                end else begin
                    tc_next    = 1'b1;
                    count_next = sat_mode ? '0 : WIDTH'(count_x + MOD_X - STEP_X);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            running <= 1'b0;
            tc      <= 1'b0;
        end else begin
            count   <= count_next;
            running <= (state_next == ST_RUN);
            tc      <= tc_next;
        end
    end

    if (STEP < 1 || STEP > MAX_VAL || MAX_VAL > (2**WIDTH - 1) || PRESCALE < 1) begin : g_param_check
        $error("updown_counter_pro: illegal WIDTH/MAX_VAL/STEP/PRESCALE combination");
    end

endmodule

// File: tb/tb_updown_counter_pro.sv
// Directed, table-driven bench for updown_counter_pro (MAX_VAL=9); a second
// instance with STEP=3 covers multi-step wrap/saturate corners.
module tb_updown_counter_pro;

    typedef struct {
        logic       rst;
        logic       start;
        logic       stop;
        logic       load;
        logic [6:0] load_val;
        logic       up_down;
        logic       sat_mode;
        logic [6:0] exp_count;
        logic       exp_running;
        logic       exp_tc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, start, stop, load, up_down, sat_mode;
    logic [6:0] load_val;
    logic [6:0] count;
    logic       running, tc;

    logic       b_rst, b_start, b_stop, b_load, b_up_down, b_sat_mode;
    logic [6:0] b_load_val;
    logic [6:0] b_count;
    logic       b_running, b_tc;

    int n_cmp  = 0;
    int n_fail = 0;

    vec_t vecs[$];
    vec_t bvecs[$];

    always #5 clk = ~clk;

    updown_counter_pro #(
        .WIDTH(7), .MAX_VAL(9), .STEP(1), .PRESCALE(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .load(load),
        .load_val(load_val), .up_down(up_down), .sat_mode(sat_mode),
        .count(count), .running(running), .tc(tc)
    );

    updown_counter_pro #(
        .WIDTH(7), .MAX_VAL(9), .STEP(3), .PRESCALE(4)
    ) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .stop(b_stop), .load(b_load),
        .load_val(b_load_val), .up_down(b_up_down), .sat_mode(b_sat_mode),
        .count(b_count), .running(b_running), .tc(b_tc)
    );

    function automatic vec_t mk(input logic r, input logic s, input logic p,
                                input logic l, input int lv, input logic ud,
                                input logic sm, input int ec, input logic er,
                                input logic et);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.load = l;
        v.load_val = 7'(lv); v.up_down = ud; v.sat_mode = sm;
        v.exp_count = 7'(ec); v.exp_running = er; v.exp_tc = et;
        return v;
    endfunction

    task automatic check_output(input string name, input int idx,
                                input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // Drive one vector on the selected instance, clock it, sample 1 ns later.
    task automatic apply_stimulus(input vec_t v, input bit on_b, input int idx);
        if (!on_b) begin
            rst = v.rst; start = v.start; stop = v.stop; load = v.load;
            load_val = v.load_val; up_down = v.up_down; sat_mode = v.sat_mode;
        end else begin
            b_rst = v.rst; b_start = v.start; b_stop = v.stop; b_load = v.load;
            b_load_val = v.load_val; b_up_down = v.up_down; b_sat_mode = v.sat_mode;
        end
        @(posedge clk);
        #1;
        if (!on_b) begin
            check_output("count",   idx, 32'(count),   32'(v.exp_count));
            check_output("running", idx, 32'(running), 32'(v.exp_running));
            check_output("tc",      idx, 32'(tc),      32'(v.exp_tc));
        end else begin
            check_output("b_count",   idx, 32'(b_count),   32'(v.exp_count));
            check_output("b_running", idx, 32'(b_running), 32'(v.exp_running));
            check_output("b_tc",      idx, 32'(b_tc),      32'(v.exp_tc));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0;
        load_val = '0; up_down = 1'b1; sat_mode = 1'b0;
        b_rst = 1'b1; b_start = 1'b0; b_stop = 1'b0; b_load = 1'b0;
        b_load_val = '0; b_up_down = 1'b1; b_sat_mode = 1'b0;

`ifndef UDC_PRESCALE_EN
        //              rst st sp ld lv  ud sm  cnt run tc
        vecs.push_back(mk(1, 0, 0, 0, 0,   1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,   1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,   1, 0, 0, 1, 0));
        for (int k = 1; k <= 9; k++) vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, k, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 3, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,   1, 0, 4, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 4, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,   1, 0, 4, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 5, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 6, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0,   1, 0, 7, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0,   1, 0, 7, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,   1, 0, 7, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2,   1, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 7,   1, 0, 7, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 100, 1, 0, 9, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8,   1, 1, 8, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 1, 9, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 1, 9, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 1, 9, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0, 1, 8, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,   0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 9, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 8, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,   0, 0, 7, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 3,   0, 0, 3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 3, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,   1, 0, 3, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 4, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 5, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 6, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0,   1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,   1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0,   1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,   1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 5,   1, 0, 0, 0, 0));

        // STEP=3 instance: multi-step wrap and saturate corners.
        bvecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        bvecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 1, 0));
        bvecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 1, 0));
        bvecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8, 1, 1));
        bvecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5, 1, 0));
        bvecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 1, 0));
        bvecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 9, 1, 1));
        bvecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 2, 1, 1));
        bvecs.push_back(mk(0, 0, 0, 1, 8, 1, 1, 8, 1, 0));
        bvecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 9, 1, 1));
        bvecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 9, 1, 1));
        bvecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 6, 1, 0));
        bvecs.push_back(mk(0, 0, 0, 1, 2, 0, 1, 2, 1, 0));
        bvecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
`else
        // PRESCALE=4: a count change on every 4th edge in RUN; load restarts it.
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 5, 1, 0, 5, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 5, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 5, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 5, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 6, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 6, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 6, 0, 0));
`endif

        #2;
        $display("[TB] running %0d main vectors, %0d STEP=3 vectors", vecs.size(), bvecs.size());
        foreach (vecs[i]) apply_stimulus(vecs[i], 1'b0, i);
        foreach (bvecs[i]) apply_stimulus(bvecs[i], 1'b1, i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
